// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 4-bit code-conversion blocks.
//   - mode encodings understood by conv_core
//   - scheduler FSM state encoding
//   - saturation ceiling of the error counter
package conv_pkg;

    localparam logic [1:0] MODE_EX3_BIN  = 2'b00;
    localparam logic [1:0] MODE_BIN_EX3  = 2'b01;
    localparam logic [1:0] MODE_BIN_GRAY = 2'b10;
    localparam logic [1:0] MODE_GRAY_BIN = 2'b11;

    localparam logic [7:0] ERRCNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/conv_core.sv
// conv_core: purely combinational 4-bit code converter.
// Ports:
//   mode [1:0] in  : conversion selector (MODE_* in conv_pkg)
//   din  [3:0] in  : input digit
//   dout [3:0] out : converted digit, forced to 0 when err is set
//   err        out : din is out of range for the selected mode
module conv_core
    import conv_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       err
);

    always_comb begin
        dout = 4'd0;
        err  = 1'b0;
        case (mode)
            MODE_EX3_BIN: begin
                if (din < 4'd3 || din > 4'd12) err = 1'b1;
                else                           dout = din - 4'd3;
            end
            MODE_BIN_EX3: begin
                if (din > 4'd9) err = 1'b1;
                else            dout = din + 4'd3;
            end
            MODE_BIN_GRAY: begin
                dout = din ^ (din >> 1);
            end
            default: begin
                // Gray to binary: each bit is the XOR of all gray bits at or above it.
                dout[3] = din[3];
                dout[2] = din[3] ^ din[2];
                dout[1] = din[3] ^ din[2] ^ din[1];
                dout[0] = din[3] ^ din[2] ^ din[1] ^ din[0];
            end
        endcase
    end

endmodule

// File: rtl/conv_sched.sv
// conv_sched: round-robin scheduler sharing one conv_core among NREQ requesters.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid [NREQ-1:0]     : per-requester request valid
//   req_mode  [2*NREQ-1:0]   : requester i mode at [2i+1:2i]
//   req_data  [4*NREQ-1:0]   : requester i digit at [4i+3:4i]
//   req_ready [NREQ-1:0]     : one-hot grant, only in IDLE
//   out_valid/out_ready      : result handshake
//   out_data, out_err, out_id: registered result, held while out_valid
//   busy                     : state != IDLE
//   err_cnt                  : saturating count of erroneous results
//   dbg_state                : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid may be dropped freely before that, and payload is only sampled on
// the transfer edge. Once out_valid rises it and the payload stay stable until
// the transfer.
module conv_sched
    import conv_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_mode,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_data,
    output logic              out_err,
    output logic [IDW-1:0]    out_id,
    output logic              busy,
    output logic [7:0]        err_cnt,
    output state_t            dbg_state
);

    localparam int CW = IDW + 1;

    state_t         state, state_nxt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] grant;
    logic           found;
    logic [CW-1:0]  cand;
    logic           accept;

    logic [1:0]     op_mode;
    logic [3:0]     op_data;
    logic [IDW-1:0] op_id;

    logic [3:0]     core_dout;
    logic           core_err;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last} + CW'(k);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                grant = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) req_ready = NREQ'(1) << grant;
    end

    assign accept    = (state == IDLE) && found;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CONV;
            CONV:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    conv_core u_core (
        .mode (op_mode),
        .din  (op_data),
        .dout (core_dout),
        .err  (core_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= IDW'(NREQ - 1);
            op_mode  <= '0;
            op_data  <= '0;
            op_id    <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
            out_id   <= '0;
            err_cnt  <= '0;
        end else begin
            if (accept) begin
                op_mode <= req_mode[{grant, 1'b0} +: 2];
                op_data <= req_data[{grant, 2'b00} +: 4];
                op_id   <= grant;
                last    <= grant;
            end
            if (state == CONV) begin
                out_data <= core_dout;
                out_err  <= core_err;
                out_id   <= op_id;
                if (core_err && err_cnt != ERRCNT_MAX) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
